// File: rtl/game_tick_scheduler.sv
// Frame scheduler: game_tick edge detect, speed prescaler and
// sequenced start/done phase handshake with per-phase watchdog.
module game_tick_scheduler #(
  parameter int NUM_PHASES    = 4,
  parameter int PHASE_TIMEOUT = 1023
) (
  input  logic                  clk_100mhz,
  input  logic                  reset,
  input  logic                  game_tick,
  input  logic                  pause,
  input  logic [3:0]            speed_div,
  input  logic [NUM_PHASES-1:0] phase_done,
  input  logic                  clear_flags,
  output logic [NUM_PHASES-1:0] phase_start,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  overrun,
  output logic                  timeout
);

  localparam int TW = (PHASE_TIMEOUT > 0) ?
                      $clog2(PHASE_TIMEOUT + 1) : 1;
  localparam int IW = (NUM_PHASES > 1) ?
                      $clog2(NUM_PHASES) : 1;

  localparam logic [TW-1:0] TMAX = TW'(PHASE_TIMEOUT);
  localparam logic [IW-1:0] LAST = IW'(NUM_PHASES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_ADVANCE = 2'd3;

  logic          tick_q;
  logic          tick_rise;
  logic          frame_fire;
  logic [3:0]    div_cnt;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [IW-1:0] phase_idx;
  logic [TW-1:0] timer;

  logic          done_sel;
  logic          last_phase;
  logic          wd_expire;
  logic          timeout_set;
  logic          overrun_set;

  assign tick_rise = game_tick & ~tick_q;

  // >= so that lowering speed_div mid-count fires on the next edge
  assign frame_fire = tick_rise & ~pause &
                      (div_cnt >= speed_div);

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      tick_q  <= 1'b1;
      div_cnt <= 4'd0;
    end else begin
      tick_q <= game_tick;
      if (tick_rise && !pause) begin
        if (div_cnt >= speed_div)
          div_cnt <= 4'd0;
        else
          div_cnt <= div_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    done_sel = 1'b0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (phase_idx == IW'(i))
        done_sel = phase_done[i];
    end
  end

  assign last_phase = (phase_idx == LAST);
  assign wd_expire  = (timer == TMAX);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (frame_fire)
          state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (done_sel || wd_expire)
          state_nx = S_ADVANCE;
      end
      S_ADVANCE: begin
        state_nx = last_phase ? S_IDLE : S_ISSUE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state     <= S_IDLE;
      phase_idx <= '0;
      timer     <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: begin
          if (frame_fire)
            phase_idx <= '0;
        end
        S_ISSUE: begin
          timer <= '0;
        end
        S_WAIT: begin
          if (!done_sel && !wd_expire)
            timer <= timer + 1'b1;
        end
        S_ADVANCE: begin
          if (!last_phase)
            phase_idx <= phase_idx + 1'b1;
        end
        default: begin
          phase_idx <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset)
      frame_count <= 16'd0;
    else if (state == S_ADVANCE && last_phase)
      frame_count <= frame_count + 16'd1;
  end

  assign timeout_set = (state == S_WAIT) &&
                       !done_sel && wd_expire;
  assign overrun_set = frame_fire && (state != S_IDLE);

  // a set event in the same cycle as clear_flags keeps the flag
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      overrun <= overrun_set | (overrun & ~clear_flags);
      timeout <= timeout_set | (timeout & ~clear_flags);
    end
  end

  always_comb begin
    phase_start = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      phase_start[i] = (state == S_ISSUE) &&
                       (phase_idx == IW'(i));
    end
  end

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_ADVANCE) && last_phase;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler: directed scenarios plus random
// traffic, every cycle compared against a frame/phase model.
module tb_game_tick_scheduler;

  localparam int NP = 4;
  localparam int PT = 7;

  logic          clk_100mhz = 1'b0;
  logic          reset;
  logic          game_tick;
  logic          pause;
  logic [3:0]    speed_div;
  logic [NP-1:0] phase_done;
  logic          clear_flags;
  logic [NP-1:0] phase_start;
  logic          busy;
  logic          frame_done;
  logic [15:0]   frame_count;
  logic          overrun;
  logic          timeout;

  always #5 clk_100mhz = ~clk_100mhz;

  game_tick_scheduler #(
    .NUM_PHASES    (NP),
    .PHASE_TIMEOUT (PT)
  ) dut (
    .clk_100mhz  (clk_100mhz),
    .reset       (reset),
    .game_tick   (game_tick),
    .pause       (pause),
    .speed_div   (speed_div),
    .phase_done  (phase_done),
    .clear_flags (clear_flags),
    .phase_start (phase_start),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // model: m_ph = active phase (-1 idle), m_age = cycles since
  // its start strobe, m_adv = phase finished, handing over
  int m_tq  = 1;
  int m_div = 0;
  int m_ph  = -1;
  int m_age = 0;
  bit m_adv = 1'b0;
  int m_cnt = 0;
  bit m_ovr = 1'b0;
  bit m_to  = 1'b0;
  bit m_rise;
  bit m_fire;

  always @(posedge clk_100mhz) begin
    if (reset) begin
      m_tq = 1; m_div = 0; m_ph = -1; m_age = 0;
      m_adv = 0; m_cnt = 0; m_ovr = 0; m_to = 0;
    end else begin
      m_rise = game_tick && (m_tq == 0);
      m_tq   = int'(game_tick);
      m_fire = 0;
      if (m_rise && !pause) begin
        if (m_div >= int'(speed_div)) begin
          m_fire = 1;
          m_div  = 0;
        end else begin
          m_div++;
        end
      end
      if (clear_flags) begin
        m_ovr = 0;
        m_to  = 0;
      end
      if (m_ph < 0) begin
        if (m_fire) begin
          m_ph = 0; m_age = 0; m_adv = 0;
        end
      end else begin
        if (m_fire) m_ovr = 1;
        if (m_adv) begin
          if (m_ph == NP - 1) begin
            m_cnt = (m_cnt + 1) % 65536;
            m_ph  = -1;
          end else begin
            m_ph++;
          end
          m_age = 0;
          m_adv = 0;
        end else if (m_age == 0) begin
          m_age = 1;
        end else if (phase_done[m_ph]) begin
          m_adv = 1;
        end else if (m_age == PT + 1) begin
          m_to  = 1;
          m_adv = 1;
        end else begin
          m_age++;
        end
      end
    end
  end

  always @(negedge clk_100mhz) begin
    if (mon_en) begin
      chk("start", 32'(phase_start),
          (m_ph >= 0 && !m_adv && m_age == 0) ?
          (32'd1 << m_ph) : 32'd0);
      chk("busy", 32'(busy), 32'(m_ph >= 0));
      chk("fdone", 32'(frame_done),
          32'(m_ph == NP - 1 && m_adv));
      chk("count", 32'(frame_count), 32'(m_cnt));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("timeout", 32'(timeout), 32'(m_to));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_100mhz);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic edge_pulse(input int hi, input int lo);
    game_tick = 1'b1;
    cyc(hi);
    game_tick = 1'b0;
    cyc(lo);
  endtask

  int hc;

  initial begin
    reset       = 1'b1;
    game_tick   = 1'b1;
    pause       = 1'b0;
    speed_div   = 4'd0;
    phase_done  = '1;
    clear_flags = 1'b0;
    cyc(1);
    mon_en = 1'b1;
    cyc(3);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("rst_start", 32'(phase_start), 32'd0);
    end
    chk("rst_busy", 32'(busy), 32'd0);
    game_tick = 1'b0;
    cyc(3);

    edge_pulse(3, 17);
    chk("one_frame", 32'(frame_count), 32'd1);

    do_reset();
    speed_div = 4'd2;
    repeat (9) edge_pulse(2, 18);
    chk("div2_frames", 32'(frame_count), 32'd3);

    do_reset();
    speed_div  = 4'd0;
    phase_done = 4'b1101;
    edge_pulse(2, 28);
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_count", 32'(frame_count), 32'd1);
    clear_flags = 1'b1;
    cyc(1);
    clear_flags = 1'b0;
    chk("to_clear", 32'(timeout), 32'd0);

    do_reset();
    phase_done = '0;
    edge_pulse(2, 2);
    game_tick = 1'b1;
    cyc(2);
    game_tick  = 1'b0;
    phase_done = '1;
    cyc(20);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_count", 32'(frame_count), 32'd1);

    do_reset();
    speed_div = 4'd2;
    repeat (2) edge_pulse(2, 3);
    pause = 1'b1;
    repeat (5) edge_pulse(2, 3);
    pause = 1'b0;
    chk("pause_count", 32'(frame_count), 32'd0);
    edge_pulse(2, 16);
    chk("pause_hold", 32'(frame_count), 32'd1);
    speed_div  = 4'd0;
    phase_done = 4'b1011;
    edge_pulse(2, 8);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    cyc(1);
    chk("mid_rbusy", 32'(busy), 32'd0);
    chk("mid_rcount", 32'(frame_count), 32'd0);
    chk("mid_rfdone", 32'(frame_done), 32'd0);
    reset = 1'b0;
    cyc(2);

    hc = 1;
    for (int i = 0; i < 4000; i++) begin
      phase_done  = NP'($urandom);
      pause       = ($urandom_range(0, 15) == 0);
      clear_flags = ($urandom_range(0, 31) == 0);
      reset       = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 99) == 0)
        speed_div = 4'($urandom_range(0, 3));
      if (hc == 0) begin
        game_tick = ~game_tick;
        hc = $urandom_range(1, 20);
      end else begin
        hc--;
      end
      cyc(1);
    end
    reset = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_tick_scheduler.md
# game_tick_scheduler

Frame scheduler driven by the 50 Hz `game_tick` square wave from the clock divider. It detects each rising edge and applies a programmable speed prescaler. On every resulting frame it sequences the game subsystems (e.g. input, player move, enemy move, collision/score) one at a time with a start/done handshake and a per-phase watchdog. It sits between the clock divider and the game-logic blocks and owns frame counting and frame-overrun/timeout status.

## Interface
- `NUM_PHASES`, 4: number of sequenced subsystems (1..8); phase 0 runs first.
- `PHASE_TIMEOUT`, 1023: maximum WAIT cycles minus one before a phase is abandoned; timer width = clog2(PHASE_TIMEOUT+1).
- `clk_100mhz`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `game_tick`  in  1  divider output, registered in the `clk_100mhz` domain; no synchronizer.
- `pause`  in  1  1 = stop issuing new frames.
- `speed_div`  in  4  frame fires on every (speed_div+1)-th rising edge of game_tick.
- `phase_done`  in  NUM_PHASES  per-phase completion pulse or level.
- `clear_flags`  in  1  clears sticky `overrun` and `timeout`.
- `phase_start`  out  NUM_PHASES  one-hot, single-cycle start strobe.
- `busy`  out  1  high whenever the FSM is not IDLE.
- `frame_done`  out  1  one-cycle pulse after the last phase completes.
- `frame_count`  out  16  completed-frame counter; wraps 0xFFFF->0.
- `overrun`  out  1  sticky: a frame fired while busy.
- `timeout`  out  1  sticky: any phase hit the watchdog.

## Operation
- Edge detect: `tick_q` <= `game_tick` every cycle; `tick_rise` = `game_tick` & ~`tick_q`. `tick_q` resets to 1, so a high `game_tick` straight after reset is not an edge.
- Prescaler (4-bit `div_cnt`):
  - On `tick_rise` with `pause`=0: if `div_cnt` >= `speed_div`, then `frame_fire` and `div_cnt`<=0; else `div_cnt`++.
  - `pause`=1: `tick_rise` ignored and `div_cnt` holds. A running frame still finishes.
  - The >= compare means lowering `speed_div` mid-count fires on the next edge.
- FSM states IDLE, ISSUE, WAIT, ADVANCE:
  - IDLE: on `frame_fire`, `phase_idx`<=0, go to ISSUE.
  - ISSUE: `phase_start[phase_idx]`=1 for this cycle only; `timer`<=0; go to WAIT.
  - WAIT: `phase_done[phase_idx]`=1 -> ADVANCE. Else `timer`==PHASE_TIMEOUT -> set `timeout`, ADVANCE. Else `timer`++.
  - ADVANCE: if `phase_idx`==NUM_PHASES-1, assert `frame_done`, `frame_count`++, go to IDLE; else `phase_idx`++, go to ISSUE.
- `phase_done` is sampled only in WAIT and only at `phase_idx`. Done bits of other phases, or done during ISSUE, are ignored. A level-held done from the previous frame is therefore not seen until WAIT.
- Overrun: `frame_fire` while FSM != IDLE sets `overrun`. That frame is dropped, not queued, and `div_cnt` still clears.
- `clear_flags` clears `overrun` and `timeout`. A set event in the same cycle wins, so the flag stays 1.
- Reset mid-frame: FSM -> IDLE, all strobes drop next cycle, no `frame_done`, and the counter and flags clear.
- Reset values: `phase_start`=0, `busy`=0, `frame_done`=0, `frame_count`=0, `overrun`=0, `timeout`=0; internal `div_cnt`=0, `phase_idx`=0, `timer`=0, `tick_q`=1.

## Timing
- All outputs are registered or Moore-decoded from state; there is no combinational input-to-output path.
- Cycle T is the first cycle `game_tick` is sampled 1, which produces `frame_fire`:
  - T+1: ISSUE, `phase_start[0]`=1, `busy`=1.
  - T+2: first WAIT cycle.
- When every `phase_done` is already high on its first WAIT cycle, each phase takes 3 cycles:
  - Phase k ISSUE is at T+1+3k.
  - Last ADVANCE is at T+3·NUM_PHASES, with `frame_done`=1.
  - T+3·NUM_PHASES+1: IDLE, `busy`=0, `frame_count` shows the new value.
- Timeout phase: ISSUE, then PHASE_TIMEOUT+1 WAIT cycles, then ADVANCE. `timeout` reads 1 from the cycle after the last WAIT.
- Minimum frame spacing at 50 Hz is 2,000,000 cycles, so overrun only occurs with hung phases or a bench-driven fast tick.

## Test plan
- Reset hold with `game_tick`=1, then release: no `phase_start` for 10 cycles; all outputs 0.
- `speed_div`=0, NUM_PHASES=4, all `phase_done` tied 1, one `game_tick` rise at T: `phase_start` = 0001@T+1, 0010@T+4, 0100@T+7, 1000@T+10; `frame_done`@T+12; `frame_count`=1@T+13.
- `speed_div`=2, 9 rising edges: exactly 3 frames, fired on edges 3, 6 and 9; `frame_count`=3.
- Phase 1 never done, PHASE_TIMEOUT=7: phase 1 spends 8 WAIT cycles; `timeout`=1; phases 2 and 3 still run; `frame_count`=1; `clear_flags` pulse -> `timeout`=0.
- Phase 0 held not-done and a second frame fires: `overrun`=1, no extra `phase_start[0]`; after releasing done, `frame_count` increments by 1 only.
- `pause`=1 during 5 edges: no frames and `div_cnt` frozen; assert `reset` during phase 2 WAIT: next cycle `busy`=0, `frame_count`=0, no `frame_done`.
